// File: rtl/mgmt_gpio_blink_monitor.sv
`default_nettype none
// ============================================================================
// Module      : mgmt_gpio_blink_monitor
// Description : Watches an asynchronous management GPIO pad and counts clean
//               high pulses ("blinks") of at least MIN_HIGH cycles. A run
//               passes when the latched target count is reached within the
//               latched cycle budget, and fails otherwise.
// Revision    : 1.0 - initial release
// ============================================================================
module mgmt_gpio_blink_monitor #(
   parameter int MIN_HIGH = 4,
   parameter int CNT_W    = 8,
   parameter int TMO_W    = 24
) (
   input  logic             clock,
   input  logic             resetb,
   input  logic             gpio_in,
   input  logic             enable,
   input  logic [CNT_W-1:0] target_count,
   input  logic [TMO_W-1:0] timeout_limit,
   output logic [CNT_W-1:0] blink_count,
   output logic             blink_pulse,
   output logic             busy,
   output logic             pass,
   output logic             fail,
   output logic [2:0]       state
);

   // hi_cnt only needs to reach MIN_HIGH, where it saturates
   localparam int              HI_W   = (MIN_HIGH < 1) ? 1 : $clog2(MIN_HIGH + 1);
   localparam logic [HI_W-1:0] HI_MIN = HI_W'(MIN_HIGH);

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_WAIT_HIGH = 3'd1;
   localparam logic [2:0] ST_WAIT_LOW  = 3'd2;
   localparam logic [2:0] ST_PASS      = 3'd3;
   localparam logic [2:0] ST_FAIL      = 3'd4;

   logic [2:0]       r_state;
   logic [2:0]       w_state_nxt;

   logic             r_sync1;
   logic             r_gpio_s;
   logic             r_gpio_d;
   logic             w_rise;
   logic             w_fall;

   logic [CNT_W-1:0] r_target;
   logic [TMO_W-1:0] r_limit;
   logic [TMO_W-1:0] r_timer;
   logic [HI_W-1:0]  r_hi_cnt;
   logic [CNT_W-1:0] r_blink_count;
   logic             r_blink_pulse;

   logic             w_busy_st;
   logic             w_timeout;
   logic             w_blink_ok;
   logic             w_blink_final;
   logic [CNT_W-1:0] w_count_inc;

   // Edge detect on the synchronized pad level
   assign w_rise = r_gpio_s & ~r_gpio_d;
   assign w_fall = ~r_gpio_s & r_gpio_d;

   // Run events: a blink is a fall after a long-enough high phase; the
   // final blink is the one that makes the count reach the target.
   assign w_busy_st     = (r_state == ST_WAIT_HIGH) || (r_state == ST_WAIT_LOW);
   assign w_timeout     = w_busy_st && (r_timer == (r_limit - TMO_W'(1)));
   assign w_blink_ok    = (r_state == ST_WAIT_LOW) && w_fall && (r_hi_cnt >= HI_MIN);
   assign w_count_inc   = r_blink_count + CNT_W'(1);
   assign w_blink_final = w_blink_ok && (w_count_inc == r_target);

   assign state       = r_state;
   assign blink_count = r_blink_count;
   assign blink_pulse = r_blink_pulse;

   // State register
   always_ff @(posedge clock) begin
      if (!resetb) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; dropping enable aborts from any state, and a final
   // blink wins over a timeout landing on the same cycle
   always_comb begin
      w_state_nxt = r_state;
      if (!enable) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (target_count == '0) begin
                  w_state_nxt = ST_PASS;
               end else begin
                  w_state_nxt = ST_WAIT_HIGH;
               end
            end
            ST_WAIT_HIGH: begin
               if (w_timeout) begin
                  w_state_nxt = ST_FAIL;
               end else if (w_rise) begin
                  w_state_nxt = ST_WAIT_LOW;
               end
            end
            ST_WAIT_LOW: begin
               if (w_blink_final) begin
                  w_state_nxt = ST_PASS;
               end else if (w_timeout) begin
                  w_state_nxt = ST_FAIL;
               end else if (w_fall) begin
                  w_state_nxt = ST_WAIT_HIGH;
               end
            end
            ST_PASS: w_state_nxt = ST_PASS;
            ST_FAIL: w_state_nxt = ST_FAIL;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Status outputs decoded from the current state
   always_comb begin
      busy = 1'b0;
      pass = 1'b0;
      fail = 1'b0;
      case (r_state)
         ST_WAIT_HIGH: busy = 1'b1;
         ST_WAIT_LOW:  busy = 1'b1;
         ST_PASS:      pass = 1'b1;
         ST_FAIL:      fail = 1'b1;
         default: begin
            busy = 1'b0;
            pass = 1'b0;
            fail = 1'b0;
         end
      endcase
   end

   // Two-flop synchronizer plus one delay stage for edge detection
   always_ff @(posedge clock) begin
      if (!resetb) begin
         r_sync1  <= 1'b0;
         r_gpio_s <= 1'b0;
         r_gpio_d <= 1'b0;
      end else begin
         r_sync1  <= gpio_in;
         r_gpio_s <= r_sync1;
         r_gpio_d <= r_gpio_s;
      end
   end

   // Run datapath: operand latch at start, cycle timer, high-width counter,
   // blink counter and its one-cycle strobe
   always_ff @(posedge clock) begin
      if (!resetb) begin
         r_target      <= '0;
         r_limit       <= '0;
         r_timer       <= '0;
         r_hi_cnt      <= '0;
         r_blink_count <= '0;
         r_blink_pulse <= 1'b0;
      end else begin
         r_blink_pulse <= 1'b0;
         if (r_state == ST_IDLE) begin
            if (enable) begin
               r_target      <= target_count;
               r_limit       <= timeout_limit;
               r_timer       <= '0;
               r_hi_cnt      <= '0;
               r_blink_count <= '0;
            end
         end else if (w_busy_st) begin
            r_timer <= r_timer + TMO_W'(1);
            if (r_state == ST_WAIT_HIGH) begin
               if (w_rise) begin
                  r_hi_cnt <= HI_W'(1);
               end
            end else if (r_gpio_s && (r_hi_cnt < HI_MIN)) begin
               r_hi_cnt <= r_hi_cnt + HI_W'(1);
            end
            // The count never exceeds the target, so it cannot wrap
            if (w_blink_ok && enable) begin
               r_blink_count <= w_count_inc;
               r_blink_pulse <= 1'b1;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mgmt_gpio_blink_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mgmt_gpio_blink_monitor
// Description : Randomized and directed bench for the GPIO blink monitor,
//               checked against a pulse-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mgmt_gpio_blink_monitor;

   localparam int MIN_HIGH = 4;
   localparam int WMAX     = 2048;

   logic        clock = 1'b0;
   logic        resetb;
   logic        gpio_in;
   logic        enable;
   logic [7:0]  target_count;
   logic [23:0] timeout_limit;
   logic [7:0]  blink_count;
   logic        blink_pulse;
   logic        busy;
   logic        pass;
   logic        fail;
   logic [2:0]  state;

   mgmt_gpio_blink_monitor #(
      .MIN_HIGH (MIN_HIGH),
      .CNT_W    (8),
      .TMO_W    (24)
   ) dut (
      .clock         (clock),
      .resetb        (resetb),
      .gpio_in       (gpio_in),
      .enable        (enable),
      .target_count  (target_count),
      .timeout_limit (timeout_limit),
      .blink_count   (blink_count),
      .blink_pulse   (blink_pulse),
      .busy          (busy),
      .pass          (pass),
      .fail          (fail),
      .state         (state)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_pass   = 0;

   // Pad waveform: wave[j] is the level presented at the j-th clock edge of a run
   bit wave [0:WMAX-1];
   int wave_len;
   bit wave_pre;

   // Expected results; sample index i means the value seen after the i-th
   // edge of the run (index 1 = first edge after the start edge)
   int exp_count, exp_pass_at, exp_fail_at, exp_np, exp_sig;
   int obs_count, obs_pass_at, obs_fail_at, obs_np, obs_sig;
   int obs_end_pass, obs_end_fail, obs_after_state, obs_after_count;

   task automatic wave_clear(input bit pre);
      wave_pre = pre;
      wave_len = 0;
   endtask

   task automatic add_seg(input bit lvl, input int dur);
      for (int k = 0; k < dur; k++) begin
         if (wave_len < WMAX) begin
            wave[wave_len] = lvl;
            wave_len++;
         end
      end
   endtask

   // Reference model: walk the pad's high pulses. A pulse counts only if
   // it begins with a rise seen during the run and is at least MIN_HIGH
   // long; it is judged 2 edges after the pad falls (synchronizer latency)
   // and is seen one sample later. The run times out at edge 'limit'.
   task automatic model(input int target, input int limit);
      int len;
      int hi_start;
      bit prev;
      len = wave_len;
      exp_count = 0; exp_pass_at = 0; exp_fail_at = 0; exp_np = 0; exp_sig = 0;
      if (target == 0) begin
         exp_pass_at = 1;
         return;
      end
      prev     = wave_pre;
      hi_start = -1;
      for (int j = 0; j < len; j++) begin
         if (!prev && wave[j]) begin
            hi_start = j;
         end else if (prev && !wave[j] && hi_start >= 0) begin
            if (j + 2 > limit || j + 3 > len) break;
            if (j - hi_start >= MIN_HIGH) begin
               exp_count++;
               exp_np++;
               exp_sig = exp_sig * 31 + (j + 3);
               if (exp_count == target) begin
                  exp_pass_at = j + 3;
                  return;
               end
            end
            hi_start = -1;
         end
         prev = wave[j];
      end
      if (limit + 1 <= len) exp_fail_at = limit + 1;
   endtask

   // Drive one run with the current waveform and record what the DUT did
   task automatic run_wave(input int target, input int limit, input bit keep_en);
      int len;
      len = wave_len;
      @(negedge clock);
      enable  = 1'b0;
      gpio_in = wave_pre;
      repeat (4) @(negedge clock);
      target_count  = target[7:0];
      timeout_limit = limit[23:0];
      enable        = 1'b1;
      gpio_in       = wave[0];
      obs_pass_at = 0; obs_fail_at = 0; obs_np = 0; obs_sig = 0;
      for (int i = 1; i <= len; i++) begin
         @(negedge clock);
         if (blink_pulse === 1'b1) begin
            obs_np++;
            obs_sig = obs_sig * 31 + i;
         end
         if (pass === 1'b1 && obs_pass_at == 0) obs_pass_at = i;
         if (fail === 1'b1 && obs_fail_at == 0) obs_fail_at = i;
         if (i < len) gpio_in = wave[i];
      end
      obs_count    = int'(blink_count);
      obs_end_pass = int'(pass);
      obs_end_fail = int'(fail);
      if (!keep_en) begin
         enable = 1'b0;
         @(negedge clock);
         obs_after_state = int'(state);
         obs_after_count = int'(blink_count);
      end
   endtask

   task automatic test_reset;
      resetb = 1'b0; enable = 1'b0; gpio_in = 1'b0;
      target_count = '0; timeout_limit = '0;
      repeat (3) @(negedge clock);
      n_checks++; if (state !== 3'd0) $display("FAIL reset_state: got %0d want 0", state); else n_pass++;
      n_checks++; if (blink_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", blink_count); else n_pass++;
      n_checks++; if ({busy, pass, fail, blink_pulse} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {busy, pass, fail, blink_pulse}); else n_pass++;
      resetb = 1'b1;
      @(negedge clock);
      n_checks++; if (state !== 3'd0) $display("FAIL reset_idle_after: got %0d want 0", state); else n_pass++;
   endtask

   task automatic test_basic;
      wave_clear(1'b0);
      add_seg(1'b0, 2);
      for (int p = 0; p < 3; p++) begin
         add_seg(1'b1, 10);
         add_seg(1'b0, 10);
      end
      add_seg(1'b0, 8);
      model(3, 10000);
      run_wave(3, 10000, 1'b0);
      n_checks++; if (obs_count !== exp_count) $display("FAIL basic_count: got %0d want %0d", obs_count, exp_count); else n_pass++;
      n_checks++; if (obs_np !== exp_np || obs_sig !== exp_sig) $display("FAIL basic_pulses: got %0d/%0d want %0d/%0d", obs_np, obs_sig, exp_np, exp_sig); else n_pass++;
      n_checks++; if (obs_pass_at !== exp_pass_at) $display("FAIL basic_pass_at: got %0d want %0d", obs_pass_at, exp_pass_at); else n_pass++;
      n_checks++; if (obs_end_fail !== 0 || obs_end_pass !== 1) $display("FAIL basic_final: got pass=%0d fail=%0d want 1/0", obs_end_pass, obs_end_fail); else n_pass++;
      n_checks++; if (obs_after_state !== 0 || obs_after_count !== 3) $display("FAIL basic_abort: got st=%0d cnt=%0d want 0/3", obs_after_state, obs_after_count); else n_pass++;
   endtask

   task automatic test_glitch;
      wave_clear(1'b0);
      add_seg(1'b0, 2); add_seg(1'b1, 2); add_seg(1'b0, 4);
      add_seg(1'b1, 8); add_seg(1'b0, 8); add_seg(1'b1, 8); add_seg(1'b0, 10);
      model(2, 10000);
      run_wave(2, 10000, 1'b0);
      n_checks++; if (obs_count !== 2 || exp_count !== 2) $display("FAIL glitch_count: got %0d want 2", obs_count); else n_pass++;
      n_checks++; if (obs_np !== exp_np || obs_sig !== exp_sig) $display("FAIL glitch_pulses: got %0d/%0d want %0d/%0d", obs_np, obs_sig, exp_np, exp_sig); else n_pass++;
      n_checks++; if (obs_pass_at !== exp_pass_at) $display("FAIL glitch_pass_at: got %0d want %0d", obs_pass_at, exp_pass_at); else n_pass++;
   endtask

   task automatic test_timeout;
      wave_clear(1'b0);
      add_seg(1'b0, 2); add_seg(1'b1, 8); add_seg(1'b0, 95);
      model(5, 100);
      run_wave(5, 100, 1'b0);
      n_checks++; if (obs_fail_at !== exp_fail_at || obs_fail_at !== 101) $display("FAIL timeout_at: got %0d want %0d", obs_fail_at, exp_fail_at); else n_pass++;
      n_checks++; if (obs_count !== exp_count) $display("FAIL timeout_count: got %0d want %0d", obs_count, exp_count); else n_pass++;
      n_checks++; if (obs_end_pass !== 0 || obs_end_fail !== 1) $display("FAIL timeout_final: got pass=%0d fail=%0d want 0/1", obs_end_pass, obs_end_fail); else n_pass++;
   endtask

   task automatic test_pass_timeout_tie;
      // Second pulse falls at edge 38 and is judged at edge 40 = limit
      wave_clear(1'b0);
      add_seg(1'b0, 2); add_seg(1'b1, 6); add_seg(1'b0, 12); add_seg(1'b1, 18); add_seg(1'b0, 7);
      model(2, 40);
      run_wave(2, 40, 1'b0);
      n_checks++; if (obs_pass_at !== exp_pass_at || obs_pass_at !== 41) $display("FAIL tie_pass_at: got %0d want %0d", obs_pass_at, exp_pass_at); else n_pass++;
      n_checks++; if (obs_fail_at !== 0) $display("FAIL tie_no_fail: got %0d want 0", obs_fail_at); else n_pass++;
      n_checks++; if (obs_count !== exp_count) $display("FAIL tie_count: got %0d want %0d", obs_count, exp_count); else n_pass++;
   endtask

   task automatic test_high_at_start;
      wave_clear(1'b1);
      add_seg(1'b1, 5); add_seg(1'b0, 5); add_seg(1'b1, 6); add_seg(1'b0, 14);
      model(1, 200);
      run_wave(1, 200, 1'b0);
      n_checks++; if (obs_np !== exp_np || obs_sig !== exp_sig) $display("FAIL hstart_pulses: got %0d/%0d want %0d/%0d", obs_np, obs_sig, exp_np, exp_sig); else n_pass++;
      n_checks++; if (obs_pass_at !== exp_pass_at) $display("FAIL hstart_pass_at: got %0d want %0d", obs_pass_at, exp_pass_at); else n_pass++;
      n_checks++; if (obs_count !== 1) $display("FAIL hstart_count: got %0d want 1", obs_count); else n_pass++;
   endtask

   task automatic test_abort;
      wave_clear(1'b0);
      add_seg(1'b0, 2); add_seg(1'b1, 6); add_seg(1'b0, 6); add_seg(1'b1, 6); add_seg(1'b0, 10);
      model(4, 500);
      run_wave(4, 500, 1'b0);
      n_checks++; if (obs_end_pass !== 0 || obs_end_fail !== 0) $display("FAIL abort_running: got pass=%0d fail=%0d want 0/0", obs_end_pass, obs_end_fail); else n_pass++;
      n_checks++; if (obs_after_state !== 0) $display("FAIL abort_state: got %0d want 0", obs_after_state); else n_pass++;
      n_checks++; if (obs_after_count !== exp_count) $display("FAIL abort_hold: got %0d want %0d", obs_after_count, exp_count); else n_pass++;
   endtask

   task automatic test_reset_mid_run;
      wave_clear(1'b0);
      add_seg(1'b0, 2); add_seg(1'b1, 6); add_seg(1'b0, 6); add_seg(1'b1, 6); add_seg(1'b0, 6);
      model(5, 1000);
      run_wave(5, 1000, 1'b1);
      n_checks++; if (obs_count !== exp_count || obs_count !== 2) $display("FAIL midrst_precount: got %0d want 2", obs_count); else n_pass++;
      resetb = 1'b0;
      @(negedge clock);
      n_checks++; if ({state, busy, pass, fail, blink_pulse} !== 7'd0 || blink_count !== 8'd0) $display("FAIL midrst_clear: got st=%0d flags=%b cnt=%0d want all 0", state, {busy, pass, fail, blink_pulse}, blink_count); else n_pass++;
      resetb = 1'b1;
      @(negedge clock);
      n_checks++; if (busy !== 1'b1 || state !== 3'd1) $display("FAIL midrst_restart: got busy=%0d st=%0d want 1/1", busy, state); else n_pass++;
      repeat (3) @(negedge clock);
      n_checks++; if (blink_count !== 8'd0) $display("FAIL midrst_fresh_count: got %0d want 0", blink_count); else n_pass++;
      enable = 1'b0;
      wave_clear(1'b0);
      add_seg(1'b0, 4);
      model(0, 50);
      run_wave(0, 50, 1'b0);
      n_checks++; if (obs_pass_at !== exp_pass_at || obs_pass_at !== 1) $display("FAIL zero_target_pass_at: got %0d want 1", obs_pass_at); else n_pass++;
      n_checks++; if (obs_count !== 0) $display("FAIL zero_target_count: got %0d want 0", obs_count); else n_pass++;
   endtask

   task automatic test_random;
      int tgt, lim;
      bit pre, lvl;
      for (int r = 0; r < 10; r++) begin
         pre = 1'($urandom_range(0, 1));
         tgt = int'($urandom_range(1, 4));
         lim = int'($urandom_range(30, 150));
         wave_clear(pre);
         lvl = pre;
         while (wave_len < lim + 4) begin
            add_seg(lvl, int'($urandom_range(1, 10)));
            lvl = ~lvl;
         end
         wave_len = lim + 4;
         model(tgt, lim);
         run_wave(tgt, lim, 1'b0);
         n_checks++; if (obs_count !== exp_count) $display("FAIL rnd%0d_count: got %0d want %0d", r, obs_count, exp_count); else n_pass++;
         n_checks++; if (obs_pass_at !== exp_pass_at) $display("FAIL rnd%0d_pass_at: got %0d want %0d", r, obs_pass_at, exp_pass_at); else n_pass++;
         n_checks++; if (obs_fail_at !== exp_fail_at) $display("FAIL rnd%0d_fail_at: got %0d want %0d", r, obs_fail_at, exp_fail_at); else n_pass++;
         n_checks++; if (obs_np !== exp_np || obs_sig !== exp_sig) $display("FAIL rnd%0d_pulses: got %0d/%0d want %0d/%0d", r, obs_np, obs_sig, exp_np, exp_sig); else n_pass++;
         n_checks++; if (obs_after_state !== 0 || obs_after_count !== exp_count) $display("FAIL rnd%0d_abort: got st=%0d cnt=%0d want 0/%0d", r, obs_after_state, obs_after_count, exp_count); else n_pass++;
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_glitch;
      test_timeout;
      test_pass_timeout_tie;
      test_high_at_start;
      test_abort;
      test_reset_mid_run;
      test_random;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mgmt_gpio_blink_monitor.md
MGMT_GPIO_BLINK_MONITOR -- requirements
Module: mgmt_gpio_blink_monitor

Interface
REQ-001 The block SHALL take parameter MIN_HIGH, default 4: minimum synchronized high width in clock cycles for a pulse to count as a blink.
REQ-002 The block SHALL take parameter CNT_W, default 8: width of the target and blink counters.
REQ-003 The block SHALL take parameter TMO_W, default 24: width of the timeout limit and timer.
REQ-004 Port clock  input  1: single clock; all logic on its rising edge.
REQ-005 Port resetb  input  1: reset, synchronous, active-low.
REQ-006 Port gpio_in  input  1: management GPIO pad level, asynchronous to clock.
REQ-007 Port enable  input  1: level; high starts and holds a check run, low aborts it.
REQ-008 Port target_count  input  CNT_W: number of blinks required for pass; sampled at start.
REQ-009 Port timeout_limit  input  TMO_W: cycle budget for the run; sampled at start.
REQ-010 Port blink_count  output  CNT_W: blinks counted in the current or last run.
REQ-011 Port blink_pulse  output  1: one-cycle strobe per counted blink.
REQ-012 Port busy  output  1: high in WAIT_HIGH or WAIT_LOW.
REQ-013 Port pass  output  1: high in state PASS.
REQ-014 Port fail  output  1: high in state FAIL.
REQ-015 Port state  output  3: encoded FSM state: IDLE=0, WAIT_HIGH=1, WAIT_LOW=2, PASS=3, FAIL=4.

Function
REQ-016 gpio_in SHALL pass through a 2-flop synchronizer to gpio_s; gpio_d SHALL be gpio_s delayed by one cycle; rise = gpio_s & ~gpio_d; fall = ~gpio_s & gpio_d.
REQ-017 IDLE with enable=1 SHALL go to WAIT_HIGH next cycle, latch target_count and timeout_limit, and clear blink_count, timer and hi_cnt.
REQ-018 If the latched target is 0, the FSM SHALL go from IDLE directly to PASS instead.
REQ-019 WAIT_HIGH on rise SHALL go to WAIT_LOW with hi_cnt=1.
REQ-020 A level already high at start SHALL NOT count; counting requires a fresh rise.
REQ-021 In WAIT_LOW, hi_cnt SHALL increment each cycle gpio_s=1, saturating at MIN_HIGH.
REQ-022 WAIT_LOW on fall with hi_cnt>=MIN_HIGH SHALL increment blink_count, assert blink_pulse for the next cycle only, and go to PASS if the new count equals the target, else to WAIT_HIGH.
REQ-023 WAIT_LOW on fall with hi_cnt<MIN_HIGH SHALL treat the pulse as a glitch: return to WAIT_HIGH with no count and no strobe.
REQ-024 timer SHALL increment every cycle in WAIT_HIGH/WAIT_LOW.
REQ-025 When timer reaches latched limit-1 and no passing blink occurs that cycle, the FSM SHALL go to FAIL.
REQ-026 If a passing blink and timeout occur in the same cycle, the FSM SHALL go to PASS.
REQ-027 PASS and FAIL SHALL hold until enable=0, then go to IDLE.
REQ-028 enable=0 in any state SHALL go to IDLE next cycle; blink_count SHALL hold its value until the next start.
REQ-029 blink_count SHALL NOT wrap: with target at its maximum, the run ends in PASS before overflow.

Reset
REQ-030 resetb=0 at a rising clock edge SHALL force state=IDLE, blink_count=0, blink_pulse=0, pass=0, fail=0, busy=0, timer=0, hi_cnt=0, and synchronizer flops to 0, including mid-run.
REQ-031 After reset release with enable already 1, a new run SHALL start on the first cycle after release.

Verification
REQ-032 target=3, limit=10000, three 10-cycle-high/10-cycle-low pulses -> blink_pulse thrice, blink_count=3, pass=1, fail=0.
REQ-033 target=2, a 2-cycle-high pulse then two 8-cycle pulses -> glitch ignored, blink_count=2, pass=1.
REQ-034 target=5, limit=100, one valid blink only -> fail=1 when timer reaches 99, blink_count=1.
REQ-035 Timing contrived so the 2nd (final) blink's fall coincides with timer=limit-1 -> pass=1, fail=0.
REQ-036 gpio_in high at start, target=1: falls, then one valid pulse -> blink_count=1 only after the second rise/fall.
REQ-037 resetb=0 mid-run with blink_count=2 -> all outputs 0 next cycle; a fresh run restarts from 0; target=0 -> PASS the cycle after start.
